// File: rtl/mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arb
// Brief    : Round-robin time-sharing of one pipelined signed multiplier among
//            NREQ requesters, returning tagged in-order responses.
//            Optional MUL_SHARE_ARB_STATS_EN adds issue/idle counters.
// Revision : 1.0
// ============================================================================
module mul_share_arb #(
    parameter  int WIDTH = 16,
    parameter  int NREQ  = 4,
    parameter  int LAT   = 1,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic [2*WIDTH-1:0]    mul_p,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_data,
    output logic                  busy
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    output logic [31:0]           stat_issued,
    output logic [31:0]           stat_idle
`endif
);

    logic [IDW-1:0]   r_ptr;
    logic [LAT:0]     r_tag_v;
    logic [IDW-1:0]   r_tag_id [0:LAT];

    logic [IDW:0]     w_cand;
    logic [IDW-1:0]   w_gidx;
    logic [IDW-1:0]   w_nxt_ptr;
    logic             w_xfer;
    logic [NREQ-1:0]  w_grant;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    // Search upward from r_ptr; the one extra bit in w_cand lets the
    // wrap be an explicit subtract, so non-power-of-two NREQ works.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_xfer  = 1'b0;
        w_cand  = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_cand = {1'b0, r_ptr} + (IDW+1)'(off);
            if (w_cand >= (IDW+1)'(NREQ)) begin
                w_cand = w_cand - (IDW+1)'(NREQ);
            end
            if (!w_xfer && req_valid[w_cand[IDW-1:0]]) begin
                w_xfer = 1'b1;
                w_gidx = w_cand[IDW-1:0];
            end
        end
        if (w_xfer) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = req_a[i*WIDTH +: WIDTH];
                w_sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_nxt_ptr = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);
    assign req_ready = w_grant;
    assign busy      = rsp_valid | (|r_tag_v);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            r_tag_v   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            for (int s = 0; s <= LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            if (w_xfer) begin
                r_ptr <= w_nxt_ptr;
                mul_a <= w_sel_a;
                mul_b <= w_sel_b;
            end
            // Tag travels alongside the multiplier pipeline; the final stage
            // lines up with mul_p for the operands it describes.
            r_tag_v[0]  <= w_xfer;
            r_tag_id[0] <= w_gidx;
            for (int s = 1; s <= LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
            rsp_valid <= r_tag_v[LAT];
            if (r_tag_v[LAT]) begin
                rsp_data <= mul_p;
                rsp_id   <= r_tag_id[LAT];
            end
        end
    end

`ifdef MUL_SHARE_ARB_STATS_EN
    logic [31:0] r_issued;
    logic [31:0] r_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued <= '0;
            r_idle   <= '0;
        end else begin
            if (w_xfer) begin
                r_issued <= r_issued + 32'd1;
            end
            if (req_valid == '0) begin
                r_idle <= r_idle + 32'd1;
            end
        end
    end

    assign stat_issued = r_issued;
    assign stat_idle   = r_idle;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_share_arb
// Brief    : Self-checking bench: NREQ=4/LAT=1 and NREQ=3/LAT=2 instances
//            against a round-robin scoreboard model.
// Revision : 1.0
// ============================================================================
module tb_mul_share_arb;
    localparam int W = 16;

    typedef struct {
        int id;
        int prod;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]     v4 = '0;
    logic [4*W-1:0] a4 = '0;
    logic [4*W-1:0] b4 = '0;
    logic [3:0]     rdy4;
    logic [W-1:0]   ma4, mb4;
    logic [2*W-1:0] p4;
    logic           rv4;
    logic [1:0]     rid4;
    logic [2*W-1:0] rd4;
    logic           busy4;

    logic [2:0]     v3 = '0;
    logic [3*W-1:0] a3 = '0;
    logic [3*W-1:0] b3 = '0;
    logic [2:0]     rdy3;
    logic [W-1:0]   ma3, mb3;
    logic [2*W-1:0] p3, p3s;
    logic           rv3;
    logic [1:0]     rid3;
    logic [2*W-1:0] rd3;
    logic           busy3;
`ifdef MUL_SHARE_ARB_STATS_EN
    logic [31:0]    si4, sd4, si3, sd3;
`endif

    mul_share_arb #(.WIDTH(W), .NREQ(4), .LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(v4), .req_a(a4), .req_b(b4),
        .req_ready(rdy4), .mul_a(ma4), .mul_b(mb4), .mul_p(p4),
        .rsp_valid(rv4), .rsp_id(rid4), .rsp_data(rd4), .busy(busy4)
`ifdef MUL_SHARE_ARB_STATS_EN
        , .stat_issued(si4), .stat_idle(sd4)
`endif
    );

    mul_share_arb #(.WIDTH(W), .NREQ(3), .LAT(2)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_a(a3), .req_b(b3),
        .req_ready(rdy3), .mul_a(ma3), .mul_b(mb3), .mul_p(p3),
        .rsp_valid(rv3), .rsp_id(rid3), .rsp_data(rd3), .busy(busy3)
`ifdef MUL_SHARE_ARB_STATS_EN
        , .stat_issued(si3), .stat_idle(sd3)
`endif
    );

    // Stand-ins for the shared multiplier at each latency.
    always @(posedge clk) begin
        p4  <= $signed({{W{ma4[W-1]}}, ma4}) * $signed({{W{mb4[W-1]}}, mb4});
        p3s <= $signed({{W{ma3[W-1]}}, ma3}) * $signed({{W{mb3[W-1]}}, mb3});
        p3  <= p3s;
    end

    int   nerr = 0;
    int   nchk = 0;
    int   cycn = 0;
    int   mptr [2];
    int   ema  [2];
    int   emb  [2];
    int   opa  [4];
    int   opb  [4];
    exp_t q4[$];
    exp_t q3[$];

    // One clock cycle on instance `which` (0: NREQ=4, 1: NREQ=3); the other idles.
    task automatic cyc(input int which, input logic [3:0] v);
        int         n;
        int         lat;
        int         g;
        int         p;
        logic [3:0] rdy;
        exp_t       e;
        n   = (which != 0) ? 3 : 4;
        lat = (which != 0) ? 2 : 1;
        for (int i = 0; i < 4; i++) begin
            a4[i*W +: W] = opa[i][W-1:0];
            b4[i*W +: W] = opb[i][W-1:0];
        end
        for (int i = 0; i < 3; i++) begin
            a3[i*W +: W] = opa[i][W-1:0];
            b3[i*W +: W] = opb[i][W-1:0];
        end
        if (which == 0) begin
            v4 = v;
            v3 = '0;
        end else begin
            v4 = '0;
            v3 = v[2:0];
        end
        #1;
        rdy = (which != 0) ? {1'b0, rdy3} : rdy4;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < n; k++) begin
                p = (mptr[which] + k) % n;
                if (g < 0 && v[p]) g = p;
            end
            nchk++;
            if (rdy !== ((g < 0) ? 4'b0000 : 4'(1 << g))) begin
                nerr++;
                $display("FAIL req_ready[%0d] cyc %0d: got %b exp grant %0d", which, cycn, rdy, g);
            end
            if (g >= 0) begin
                e.id   = g;
                e.prod = opa[g] * opb[g];
                e.due  = cycn + lat + 2;
                if (which == 0) q4.push_back(e);
                else            q3.push_back(e);
                mptr[which] = (g + 1) % n;
                ema[which]  = opa[g];
                emb[which]  = opb[g];
            end
        end
        @(posedge clk);
        cycn++;
        if (rst) begin
            q4.delete();
            q3.delete();
            for (int w = 0; w < 2; w++) begin
                mptr[w] = 0;
                ema[w]  = 0;
                emb[w]  = 0;
            end
        end
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            int          sz;
            logic        erv;
            logic        orv;
            logic        ob;
            logic [1:0]  oid;
            logic [31:0] od;
            logic [15:0] oma;
            logic [15:0] omb;
            exp_t        x;
            erv = 1'b0;
            x   = '{0, 0, 0};
            if (w == 0) begin
                sz = q4.size();
                if (sz > 0 && q4[0].due == cycn) begin
                    x = q4.pop_front();
                    erv = 1'b1;
                end
            end else begin
                sz = q3.size();
                if (sz > 0 && q3[0].due == cycn) begin
                    x = q3.pop_front();
                    erv = 1'b1;
                end
            end
            orv = (w != 0) ? rv3   : rv4;
            ob  = (w != 0) ? busy3 : busy4;
            oid = (w != 0) ? rid3  : rid4;
            od  = (w != 0) ? rd3   : rd4;
            oma = (w != 0) ? ma3   : ma4;
            omb = (w != 0) ? mb3   : mb4;
            nchk++;
            if (orv !== erv) begin
                nerr++;
                $display("FAIL rsp_valid[%0d] cyc %0d: got %b exp %b", w, cycn, orv, erv);
            end
            if (erv) begin
                nchk++;
                if (oid !== 2'(x.id)) begin
                    nerr++;
                    $display("FAIL rsp_id[%0d] cyc %0d: got %0d exp %0d", w, cycn, oid, x.id);
                end
                nchk++;
                if (od !== 32'(x.prod)) begin
                    nerr++;
                    $display("FAIL rsp_data[%0d] cyc %0d: got %h exp %h", w, cycn, od, 32'(x.prod));
                end
            end
            nchk++;
            if (ob !== (sz > 0)) begin
                nerr++;
                $display("FAIL busy[%0d] cyc %0d: got %b exp %b", w, cycn, ob, (sz > 0));
            end
            nchk++;
            if (oma !== 16'(ema[w]) || omb !== 16'(emb[w])) begin
                nerr++;
                $display("FAIL mul_ab[%0d] cyc %0d: got %h/%h exp %h/%h", w, cycn, oma, omb,
                         16'(ema[w]), 16'(emb[w]));
            end
        end
    endtask

    task automatic check_rsp_regs_zero(input string tag);
        nchk++;
        if (rid4 !== 2'd0 || rd4 !== 32'd0 || rid3 !== 2'd0 || rd3 !== 32'd0) begin
            nerr++;
            $display("FAIL %s rsp regs: got %0d/%h %0d/%h exp 0", tag, rid4, rd4, rid3, rd3);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'b0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 4'b0000);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(0, 4'b0000);
        cyc(0, 4'b1111);
        check_rsp_regs_zero("reset");
        rst = 1'b0;
    endtask

    task automatic test_single();
        opa[2] = -3;
        opb[2] = 7;
        cyc(0, 4'b0100);
        drain(4);
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            opa[i] = i + 1;
            opb[i] = 10;
        end
        for (int i = 0; i < 8; i++) cyc(0, 4'b1111);
        drain(4);
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        opa[0] = 5;  opb[0] = -6;
        opa[1] = 9;  opb[1] = 9;
        opa[2] = -7; opb[2] = 11;
        cyc(1, 4'b0001);
        cyc(1, 4'b0001);
        cyc(1, 4'b0100);
        cyc(1, 4'b0111);
        cyc(1, 4'b0111);
        cyc(1, 4'b0111);
        for (int i = 0; i < 5; i++) cyc(1, 4'b0000);
    endtask

    task automatic test_extremes();
        opa[1] = -32768; opb[1] = -32768;
        cyc(0, 4'b0010);
        opa[1] = 32767;  opb[1] = -32768;
        cyc(0, 4'b0010);
        drain(4);
    endtask

    task automatic test_back_to_back();
        opa[3] = 123; opb[3] = -45;
        for (int i = 0; i < 6; i++) cyc(0, 4'b1000);
        drain(4);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            opa[i] = 100 + i;
            opb[i] = -(i + 2);
        end
        cyc(0, 4'b1111);
        cyc(0, 4'b1111);
        rst = 1'b1;
        cyc(0, 4'b1111);
        check_rsp_regs_zero("reset_mid");
        rst = 1'b0;
        cyc(0, 4'b0110);
        drain(4);
    endtask

    task automatic test_random();
        int         which;
        logic [3:0] v;
        for (int c = 0; c < 300; c++) begin
            which = int'($urandom_range(0, 1));
            v     = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                opa[i] = int'($signed(16'($urandom)));
                opb[i] = int'($signed(16'($urandom)));
            end
            rst = ($urandom_range(0, 59) == 0);
            cyc(which, v);
        end
        rst = 1'b0;
        drain(6);
    endtask

`ifdef MUL_SHARE_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 5; i++) cyc(0, 4'b1111);
        for (int i = 0; i < 3; i++) cyc(0, 4'b0000);
        nchk++;
        if (si4 !== 32'd5 || sd4 !== 32'd3) begin
            nerr++;
            $display("FAIL stats4: got issued=%0d idle=%0d exp 5/3", si4, sd4);
        end
        nchk++;
        if (si3 !== 32'd0 || sd3 !== 32'd8) begin
            nerr++;
            $display("FAIL stats3: got issued=%0d idle=%0d exp 0/8", si3, sd3);
        end
        drain(4);
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) begin
            opa[i] = 0;
            opb[i] = 0;
        end
        for (int w = 0; w < 2; w++) begin
            mptr[w] = 0;
            ema[w]  = 0;
            emb[w]  = 0;
        end
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_ptr_wrap();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef MUL_SHARE_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
